// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: buffers one input vector, broadcasts it to the neuron array as a
// gap-free burst, collects the per-neuron activations and streams them out in order.
module layer_seq_ctrl #(
  parameter int numNeuron   = 30,
  parameter int numWeight   = 784,
  parameter int dataWidth   = 16,
  parameter int waitTimeout = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [dataWidth-1:0]           in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [dataWidth-1:0]           neuron_in,
  output logic                           neuron_in_valid,
  input  logic [numNeuron*dataWidth-1:0] neuron_out,
  input  logic [numNeuron-1:0]           neuron_outvalid,
  output logic [dataWidth-1:0]           out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           busy,
  output logic                           layer_done,
  output logic                           err
);

  localparam int WW  = $clog2(numWeight + 1);
  localparam int JW  = $clog2(numNeuron + 1);
  localparam int TW  = $clog2(waitTimeout + 1);
  localparam int AW  = $clog2(numWeight);
  localparam int NAW = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [WW-1:0] W_LAST = WW'(numWeight - 1);
  localparam logic [JW-1:0] J_LAST = JW'(numNeuron - 1);
  localparam logic [TW-1:0] T_LAST = TW'(waitTimeout - 1);

  typedef enum logic [2:0] {IDLE, LOAD, FEED, WAIT, DRAIN} state_t;

  state_t                 state, state_nx;
  logic [WW-1:0]          wcnt, wcnt_nx, k, k_nx;
  logic [JW-1:0]          j, j_nx;
  logic [TW-1:0]          tcnt, tcnt_nx;
  logic [numNeuron-1:0]   mask, mask_nx;
  logic [dataWidth-1:0]   ibuf    [numWeight];
  logic [dataWidth-1:0]   out_buf [numNeuron];
  logic [dataWidth-1:0]   out_buf_nx [numNeuron];
  logic                   in_ready_nx, niv_nx, ov_nx, ol_nx, busy_nx, done_nx, err_nx;
  logic [dataWidth-1:0]   nin_nx, od_nx;
  logic                   accept, go_drain;

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wcnt            <= '0;
      k               <= '0;
      j               <= '0;
      tcnt            <= '0;
      mask            <= '0;
      in_ready        <= 1'b0;
      neuron_in       <= '0;
      neuron_in_valid <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      busy            <= 1'b0;
      layer_done      <= 1'b0;
      err             <= 1'b0;
    end else begin
      state           <= state_nx;
      wcnt            <= wcnt_nx;
      k               <= k_nx;
      j               <= j_nx;
      tcnt            <= tcnt_nx;
      mask            <= mask_nx;
      in_ready        <= in_ready_nx;
      neuron_in       <= nin_nx;
      neuron_in_valid <= niv_nx;
      out_data        <= od_nx;
      out_valid       <= ov_nx;
      out_last        <= ol_nx;
      busy            <= busy_nx;
      layer_done      <= done_nx;
      err             <= err_nx;
    end
  end

  // Sample and activation storage carry no reset; the mask qualifies their contents.
  always_ff @(posedge clk) begin
    if (accept) ibuf[wcnt[AW-1:0]] <= in_data;
    out_buf <= out_buf_nx;
  end

  always_comb begin
    state_nx   = state;
    wcnt_nx    = wcnt;
    k_nx       = k;
    j_nx       = j;
    tcnt_nx    = tcnt;
    mask_nx    = mask;
    out_buf_nx = out_buf;
    nin_nx     = neuron_in;
    niv_nx     = 1'b0;
    od_nx      = out_data;
    ov_nx      = 1'b0;
    ol_nx      = 1'b0;
    done_nx    = 1'b0;
    err_nx     = err;
    go_drain   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          wcnt_nx  = WW'(1);
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          if (wcnt == W_LAST) begin
            wcnt_nx  = '0;
            k_nx     = '0;
            mask_nx  = '0;
            for (int i = 0; i < numNeuron; i++) out_buf_nx[i] = '0;
            state_nx = FEED;
          end else begin
            wcnt_nx = wcnt + WW'(1);
          end
        end
      end
      FEED: begin
        niv_nx = 1'b1;
        nin_nx = ibuf[k[AW-1:0]];
        if (k == W_LAST) begin
          k_nx     = '0;
          tcnt_nx  = '0;
          state_nx = WAIT;
        end else begin
          k_nx = k + WW'(1);
        end
      end
      WAIT: begin
        for (int i = 0; i < numNeuron; i++)
          if (neuron_outvalid[i]) out_buf_nx[i] = neuron_out[i*dataWidth +: dataWidth];
        mask_nx = mask | neuron_outvalid;
        if (&mask_nx) begin
          go_drain = 1'b1;
        end else if (tcnt == T_LAST) begin
          err_nx   = 1'b1;
          go_drain = 1'b1;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
        // First drain beat is presented on the same edge the mask completes.
        if (go_drain) begin
          state_nx = DRAIN;
          j_nx     = '0;
          ov_nx    = 1'b1;
          od_nx    = out_buf_nx[0];
          ol_nx    = (J_LAST == '0);
        end
      end
      DRAIN: begin
        ov_nx = 1'b1;
        ol_nx = out_last;
        if (out_valid && out_ready) begin
          if (j == J_LAST) begin
            ov_nx    = 1'b0;
            ol_nx    = 1'b0;
            done_nx  = 1'b1;
            j_nx     = '0;
            mask_nx  = '0;
            state_nx = IDLE;
          end else begin
            j_nx  = j + JW'(1);
            od_nx = out_buf[j_nx[NAW-1:0]];
            ol_nx = (j_nx == J_LAST);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    in_ready_nx = (state_nx == IDLE) || (state_nx == LOAD);
    busy_nx     = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl with a 4-neuron, 8-weight configuration and a
// hand-scripted neuron array model.
module tb_layer_seq_ctrl;
  localparam int NN = 4;
  localparam int NW = 8;
  localparam int DW = 16;
  localparam int WT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     neuron_in;
  logic              neuron_in_valid;
  logic [NN*DW-1:0]  neuron_out;
  logic [NN-1:0]     neuron_outvalid;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              busy;
  logic              layer_done;
  logic              err;

  int checks = 0;
  int errors = 0;

  layer_seq_ctrl #(.numNeuron(NN), .numWeight(NW), .dataWidth(DW), .waitTimeout(WT)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .neuron_in(neuron_in), .neuron_in_valid(neuron_in_valid),
    .neuron_out(neuron_out), .neuron_outvalid(neuron_outvalid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .layer_done(layer_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_neuron_in"}, neuron_in, 0);
    chk({tag, "_niv"}, neuron_in_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, layer_done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic load_beats(input logic [DW-1:0] b, input bit gapped);
    int n;
    for (int i = 0; i < NW; i++) begin
      in_data  = b + DW'(i);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 60) begin
        tick;
        n++;
      end
      chk("in_ready_wait", in_ready, 1);
      tick;
      if (gapped && i < NW - 1) begin
        in_valid = 1'b0;
        tick;
      end
    end
  endtask

  task automatic do_vector(input logic [DW-1:0] b, input bit gapped,
                           input logic [NN-1:0][7:0] dly, input logic [NN-1:0] miss,
                           input bit stall, input bit hold, input logic [DW-1:0] next_b,
                           input logic [DW-1:0] off, input bit err_before, input bit err_after,
                           input bit timeout);
    int n;
    int wc;
    int mx;
    logic [DW-1:0] ev;
    chk("err_pre", err, err_before);
    for (int i = 0; i < NN; i++) neuron_out[i*DW +: DW] = DW'(16 * (i + 1)) + off;
    load_beats(b, gapped);
    if (hold) begin
      in_data  = next_b;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    chk("feed_not_yet", neuron_in_valid, 0);
    chk("in_ready_drop", in_ready, 0);
    for (int s = 0; s < NW; s++) begin
      tick;
      chk("feed_valid", neuron_in_valid, 1);
      chk("feed_data", neuron_in, b + DW'(s));
    end
    tick;
    chk("feed_end", neuron_in_valid, 0);
    wc = 1;
    mx = 0;
    for (int i = 0; i < NN; i++)
      if (!miss[i] && int'(dly[i]) > mx) mx = int'(dly[i]);
    n = 0;
    while (!out_valid && n < 40) begin
      for (int i = 0; i < NN; i++) neuron_outvalid[i] = !miss[i] && (int'(dly[i]) == n);
      tick;
      neuron_outvalid = '0;
      wc++;
      n++;
    end
    chk("drain_start", out_valid, 1);
    if (timeout) chk("timeout_cycle", wc, WT);
    else         chk("mask_cycle", wc, mx + 2);
    chk("err_at_drain", err, err_after);
    for (int jj = 0; jj < NN; jj++) begin
      ev = miss[jj] ? '0 : DW'(16 * (jj + 1)) + off;
      chk("drain_data", out_data, ev);
      chk("drain_last", out_last, (jj == NN - 1));
      chk("drain_in_ready", in_ready, 0);
      if (stall && jj == 1) begin
        out_ready = 1'b0;
        repeat (3) begin
          tick;
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, ev);
          chk("stall_last", out_last, 0);
        end
        out_ready = 1'b1;
      end
      tick;
    end
    chk("done_pulse", layer_done, 1);
    chk("drain_end", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    chk("busy_end", busy, 0);
    chk("err_post", err, err_after);
    if (!hold) begin
      tick;
      chk("done_once", layer_done, 0);
    end
  endtask

  initial begin
    rst             = 1'b1;
    in_data         = '0;
    in_valid        = 1'b0;
    out_ready       = 1'b1;
    neuron_out      = '0;
    neuron_outvalid = '0;
    repeat (3) tick;
    chk_zero("reset");
    rst = 1'b0;
    tick;
    chk("in_ready_after_reset", in_ready, 1);
    chk("busy_after_reset", busy, 0);

    // basic, gapped, staggered with stall, timeout
    do_vector(16'd1, 1'b0, {8'd4, 8'd4, 8'd4, 8'd4}, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    do_vector(16'h21, 1'b1, {8'd4, 8'd4, 8'd4, 8'd4}, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    do_vector(16'h31, 1'b0, {8'd9, 8'd3, 8'd6, 8'd1}, 4'b0000, 1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    do_vector(16'h41, 1'b0, {8'd2, 8'd0, 8'd2, 8'd2}, 4'b0100, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);

    // back-to-back with err still sticky
    do_vector(16'h51, 1'b0, {8'd1, 8'd2, 8'd3, 8'd0}, 4'b0000, 1'b0, 1'b1, 16'h61, 16'd1, 1'b1, 1'b1, 1'b0);
    do_vector(16'h61, 1'b0, {8'd0, 8'd0, 8'd0, 8'd0}, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd2, 1'b1, 1'b1, 1'b0);

    // reset in the middle of the broadcast burst
    load_beats(16'h71, 1'b0);
    in_valid = 1'b0;
    repeat (5) tick;
    chk("pre_reset_sample4", neuron_in, 16'h75);
    rst = 1'b1;
    tick;
    chk_zero("mid_reset");
    tick;
    rst = 1'b0;
    tick;
    chk("in_ready_after_abort", in_ready, 1);
    chk("busy_after_abort", busy, 0);
    do_vector(16'h81, 1'b0, {8'd3, 8'd3, 8'd3, 8'd3}, 4'b0000, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule
